data_receiver: RTL
==================

// Module: data_receiver
// PURPOSE
//  Receive end of the inter-board serial data link: deserialises a framed bit stream
//  from the peer board's data sender into one ENC_DATA_BITS word.
//  Sits between the board-to-board serial pin and the network layer.
//  Pulses a completion strobe per good frame and flags malformed frames.
// PARAMETERS
//  DATA_BITS    default ENC_DATA_BITS (216)   payload bits per frame
//  SYNC_STAGES  default 2                     flops in serial_in synchroniser (>=2)
// PORTS
//  clk         in   1          system clock; the only clock
//  rst         in   1          synchronous, active-high reset
//  recv_en     in   1          1 = frame reception allowed
//  serial_in   in   1          serial line from peer sender; idles low
//  data_out    out  DATA_BITS  last correctly received payload
//  recv_done   out  1          1-cycle pulse: data_out updated this cycle
//  frame_err   out  1          1-cycle pulse: frame rejected (bad stop bit)
//  recv_busy   out  1          1 while state != IDLE
//  recv_count  out  $clog2(DATA_BITS+1)  payload bits captured in current frame
// BEHAVIOUR
//  - Reset: all synchroniser flops 0, state IDLE, data_out 0, recv_done 0,
//    frame_err 0, recv_busy 0, recv_count 0, shift register 0.
//    Reset mid-frame discards the partial frame.
//  - serial_in passes through SYNC_STAGES flops; s = synchronised bit, s_d = s delayed 1.
//    All decisions use s. Fixed input latency SYNC_STAGES cycles.
//  - Frame on the line: start bit 1, DATA_BITS payload bits MSB first, stop bit 0.
//    One bit per clk cycle.
//  - FSM:
//    IDLE: if recv_en && s==1 && s_d==0 -> RECV, recv_count=0.
//          Rising edge required: a line stuck high after reset never starts a frame.
//    RECV: each cycle shift s into LSB of shift reg, recv_count++.
//          After the cycle in which recv_count reaches DATA_BITS -> STOP.
//    STOP: sample s once.
//          s==0: data_out <= shift reg, recv_done=1 next cycle.
//          s==1: frame_err=1 next cycle, data_out unchanged.
//          Either case -> IDLE.
//  - recv_done/frame_err are registered, high exactly one cycle, never both.
//  - recv_en is checked only in IDLE; deasserting mid-frame does not abort.
//  - Back-to-back frames: the stop 0 satisfies s_d==0, so a start bit on the very
//    next cycle is accepted with zero idle gap.
//  - Latency: recv_done is high SYNC_STAGES+DATA_BITS+2 cycles after the start
//    bit appears on serial_in.
//  - recv_count saturates at DATA_BITS; it holds its value in STOP and is cleared
//    on the next start.
//  - data_out is stable between recv_done pulses.
// TESTING
//  1. Reset, recv_en=1, drive frame with payload {108{2'b10}}
//     -> data_out=={108{2'b10}}, recv_done high 1 cycle at start+220, frame_err 0.
//  2. Same frame but stop bit 1
//     -> frame_err pulse at the same cycle, recv_done 0, data_out keeps its prior value.
//  3. Hold serial_in=1 through and after reset
//     -> stays IDLE, recv_busy 0; the first 0->1 edge then starts a frame.
//  4. Assert rst midway (recv_count==100)
//     -> next cycle IDLE, data_out 0, recv_count 0; the remainder of the frame
//        produces no recv_done.
//  5. Two back-to-back frames (all-1s, then all-0s), no gap
//     -> two recv_done pulses 218 cycles apart; data_out ends all-0s.
//  6. recv_en=0 during a start bit -> ignored; recv_en dropped mid-frame -> frame completes.

Source files
------------

// File: rtl/data_receiver.sv
// Receive end of the inter-board serial link: synchronises the serial pin,
// detects framed words (start 1, payload MSB first, stop 0) and presents them to the network layer.
module data_receiver #(
    parameter int unsigned DATA_BITS   = 216,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           recv_en,
    input  logic                           serial_in,
    output logic [DATA_BITS-1:0]           data_out,
    output logic                           recv_done,
    output logic                           frame_err,
    output logic                           recv_busy,
    output logic [$clog2(DATA_BITS+1)-1:0] recv_count
);

    localparam int unsigned CW = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   vld_q;
    logic                   s_d_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_q;
    logic [CW-1:0]          count_q;
    logic                   done_q;
    logic                   err_q;
    logic                   busy_q;
    logic                   s;
    logic                   start_c;

    assign s = sync_q[SYNC_STAGES-1];

    // vld_q marks when s_d holds a real line sample, so a line already high
    // when reset releases is not mistaken for a rising edge.
    assign start_c = recv_en && s && !s_d_q && vld_q[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            vld_q   <= '0;
            s_d_q   <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
            vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
            s_d_q  <= s;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        state_q <= RECV;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RECV: begin
                    shift_q <= {shift_q[DATA_BITS-2:0], s};
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(DATA_BITS - 1)) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    // Stop bit must be low; otherwise the frame is dropped.
                    if (!s) begin
                        data_q <= shift_q;
                        done_q <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign recv_done  = done_q;
    assign frame_err  = err_q;
    assign recv_busy  = busy_q;
    assign recv_count = count_q;

endmodule
